// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and glitch-filters qa/qb/idx, then decodes
// legal Gray-code transitions into step pulses, direction and a wrapping position.
module quad_decoder #(
    parameter int CNT_WIDTH   = 4,
    parameter int FILT_LEN    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 qa,
    input  logic                 qb,
    input  logic                 idx,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 clear_err,
    output logic                 step_en,
    output logic                 up_down_n,
    output logic [CNT_WIDTH-1:0] position,
    output logic                 err
);

    localparam int FCW         = $clog2(FILT_LEN + 1);
    localparam int INIT_CYCLES = SYNC_STAGES + FILT_LEN + 1;
    localparam int ICW         = $clog2(INIT_CYCLES + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // bit 0 = qa, bit 1 = qb, bit 2 = idx
    logic [2:0] w_raw;
    logic [2:0] w_filt;

    assign w_raw = {idx, qb, qa};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_in
            logic [SYNC_STAGES-1:0] r_sync;
            logic [FCW-1:0]         r_fcnt;
            logic                   r_filt;
            logic                   w_synced;

            assign w_synced  = r_sync[SYNC_STAGES-1];
            assign w_filt[gi] = r_filt;

            // A new level is accepted only after FILT_LEN consecutive differing samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                    r_fcnt <= '0;
                    r_filt <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
                    if (w_synced != r_filt) begin
                        if (r_fcnt == FCW'(FILT_LEN - 1)) begin
                            r_filt <= w_synced;
                            r_fcnt <= '0;
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end else begin
                        r_fcnt <= '0;
                    end
                end
            end
        end
    endgenerate

    // Gray phase 00,01,11,10 -> ordinal 0,1,2,3
    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    state_t               r_state, w_state_next;
    logic [ICW-1:0]       r_init_cnt, w_init_cnt_next;
    logic [1:0]           r_prev_ab, w_prev_ab_next;
    logic                 r_prev_idx, w_prev_idx_next;
    logic                 r_step, w_step_next;
    logic                 r_dir, w_dir_next;
    logic [CNT_WIDTH-1:0] r_pos, w_pos_next;
    logic                 r_err, w_err_next;
    logic [1:0]           w_cur_ab;
    logic [1:0]           w_delta;

    assign w_cur_ab = {w_filt[0], w_filt[1]};
    assign w_delta  = gray2bin(w_cur_ab) - gray2bin(r_prev_ab);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_prev_ab  <= 2'b00;
            r_prev_idx <= 1'b0;
            r_step     <= 1'b0;
            r_dir      <= 1'b1;
            r_pos      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= w_init_cnt_next;
            r_prev_ab  <= w_prev_ab_next;
            r_prev_idx <= w_prev_idx_next;
            r_step     <= w_step_next;
            r_dir      <= w_dir_next;
            r_pos      <= w_pos_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        w_prev_ab_next  = r_prev_ab;
        w_prev_idx_next = r_prev_idx;
        w_step_next     = 1'b0;
        w_dir_next      = r_dir;
        w_pos_next      = r_pos;
        w_err_next      = clear_err ? 1'b0 : r_err;

        case (r_state)
            ST_INIT: begin
                // Wait for the sync/filter pipeline to settle before trusting prev values.
                if (r_init_cnt == ICW'(INIT_CYCLES - 1)) begin
                    w_prev_ab_next  = w_cur_ab;
                    w_prev_idx_next = w_filt[2];
                    w_init_cnt_next = '0;
                    w_state_next    = ST_RUN;
                end else begin
                    w_init_cnt_next = r_init_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // prev tracks even while disabled so re-enabling never yields a stale step.
                w_prev_ab_next  = w_cur_ab;
                w_prev_idx_next = w_filt[2];
                if (enable) begin
                    case (w_delta)
                        2'd1: begin
                            w_step_next = 1'b1;
                            w_dir_next  = 1'b1;
                            w_pos_next  = r_pos + 1'b1;
                        end
                        2'd3: begin
                            w_step_next = 1'b1;
                            w_dir_next  = 1'b0;
                            w_pos_next  = r_pos - 1'b1;
                        end
                        2'd2:    w_err_next = 1'b1;
                        default: ;
                    endcase
                    if (w_filt[2] && !r_prev_idx) begin
                        w_pos_next = load_value;
                    end
                end
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    assign step_en   = r_step;
    assign up_down_n = r_dir;
    assign position  = r_pos;
    assign err       = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: each decoded step pops an expected
// {direction, position} pair queued when the stimulus transition was driven.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       qa = 1'b1;
    logic       qb = 1'b1;
    logic       idx = 1'b0;
    logic [3:0] load_value = 4'd9;
    logic       clear_err = 1'b0;
    logic       step_en;
    logic       up_down_n;
    logic [3:0] position;
    logic       err;

    quad_decoder #(
        .CNT_WIDTH  (4),
        .FILT_LEN   (3),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .qa        (qa),
        .qb        (qb),
        .idx       (idx),
        .load_value(load_value),
        .clear_err (clear_err),
        .step_en   (step_en),
        .up_down_n (up_down_n),
        .position  (position),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dir;
        logic [3:0] pos;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_vec  = 0;
    int         n_miss = 0;
    logic [1:0] m_ab;
    logic [3:0] m_pos;
    int         lat;
    logic [1:0] up_seq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // +1 = up, -1 = down, 2 = illegal (both phases changed), 0 = no change
    function automatic int trans_kind(input logic [1:0] p, input logic [1:0] c);
        case ({p, c})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: return 1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: return -1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: return 2;
            default:                            return 0;
        endcase
    endfunction

    // Drive a new {qa,qb} level, queue the expected step, hold 8 cycles and
    // report the cycle within the hold where step_en was first seen.
    task automatic move(input logic [1:0] ab, output int first_step);
        int k;
        k = trans_kind(m_ab, ab);
        if (enable && k == 1) begin
            m_pos = m_pos + 4'd1;
            sb_q.push_back('{dir: 1'b1, pos: m_pos});
        end else if (enable && k == -1) begin
            m_pos = m_pos - 4'd1;
            sb_q.push_back('{dir: 1'b0, pos: m_pos});
        end
        m_ab = ab;
        qa = ab[1];
        qb = ab[0];
        first_step = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (step_en && first_step == 0) first_step = i;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && step_en) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_step", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("step_dir", {31'd0, up_down_n}, {31'd0, mon_e.dir});
                check_eq("step_pos", {28'd0, position}, {28'd0, mon_e.pos});
            end
        end
    end

    initial begin
        m_ab  = 2'b11;
        m_pos = 4'd0;
        // reset with qa=qb=1 held
        repeat (3) @(negedge clk);
        check_eq("rst_step_en", {31'd0, step_en}, 32'd0);
        check_eq("rst_up_down_n", {31'd0, up_down_n}, 32'd1);
        check_eq("rst_position", {28'd0, position}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("init11_position", {28'd0, position}, 32'd0);
        check_eq("init11_err", {31'd0, err}, 32'd0);

        // restart from 00 so the up sequence begins at phase 0
        rst_n = 1'b0;
        qa = 1'b0;
        qb = 1'b0;
        m_ab = 2'b00;
        m_pos = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // 16 up transitions, wrapping back to 0
        for (int i = 0; i < 16; i++) begin
            move(up_seq[(i + 1) % 4], lat);
            if (i == 0) check_eq("first_latency", lat, 32'd6);
            check_eq("up_position", {28'd0, position}, {28'd0, m_pos});
        end
        check_eq("up_dir", {31'd0, up_down_n}, 32'd1);

        // 3 down transitions: 15,14,13
        move(2'b10, lat);
        check_eq("down_position", {28'd0, position}, 32'd15);
        check_eq("down_dir", {31'd0, up_down_n}, 32'd0);
        move(2'b11, lat);
        check_eq("down_position", {28'd0, position}, 32'd14);
        move(2'b01, lat);
        check_eq("down_position", {28'd0, position}, 32'd13);

        // 2-cycle glitch on qa is filtered out
        qa = 1'b1;
        repeat (2) @(negedge clk);
        qa = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("glitch_position", {28'd0, position}, 32'd13);

        // illegal transitions and sticky err
        move(2'b00, lat);
        check_eq("pre_err_position", {28'd0, position}, 32'd12);
        move(2'b11, lat);
        check_eq("illegal_err", {31'd0, err}, 32'd1);
        check_eq("illegal_position", {28'd0, position}, 32'd12);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("clear_err", {31'd0, err}, 32'd0);
        qa = 1'b0;
        qb = 1'b0;
        m_ab = 2'b00;
        repeat (5) @(negedge clk);
        clear_err = 1'b1;          // coincides with the edge that decodes the illegal move
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("set_wins_err", {31'd0, err}, 32'd1);
        repeat (4) @(negedge clk);
        check_eq("sticky_err", {31'd0, err}, 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("clear_err2", {31'd0, err}, 32'd0);

        // index load while stepping up
        move(2'b01, lat);
        check_eq("pre_idx_position", {28'd0, position}, 32'd13);
        idx = 1'b1;
        repeat (8) @(negedge clk);
        m_pos = 4'd9;
        check_eq("idx_load", {28'd0, position}, 32'd9);
        move(2'b11, lat);
        check_eq("post_idx_position", {28'd0, position}, 32'd10);
        idx = 1'b0;
        repeat (8) @(negedge clk);

        // disabled across two transitions, then re-enable
        enable = 1'b0;
        move(2'b10, lat);
        move(2'b00, lat);
        check_eq("disabled_position", {28'd0, position}, 32'd10);
        check_eq("disabled_dir", {31'd0, up_down_n}, 32'd1);
        enable = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("reenable_position", {28'd0, position}, 32'd10);
        move(2'b01, lat);
        check_eq("reenable_step", {28'd0, position}, 32'd11);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
